ltc2195_frame_aligner: RTL and testbench

Link-training controller for the LTC2195 LVDS receiver, running in the DCO_2D (frame-rate) domain. Sweeps the shared IDELAY tap (delay_val) to find the widest eye on the frame lane, parks at the window centre, then issues ISERDES bitslip pulses until FR_out equals the expected frame pattern. Once locked, it monitors FR_out and flags or re-trains on loss of alignment.

---
 rtl/ltc2195_frame_aligner.sv | 245 ++++++++++++++++++++++++
 tb/tb_ltc2195_frame_aligner.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/ltc2195_frame_aligner.sv
// LTC2195 frame-lane link trainer: sweeps the shared IDELAY tap for the widest
// stable eye, parks at its centre, then bitslips until FR_out shows the frame pattern.
module ltc2195_frame_aligner #(
    parameter logic [3:0] FRAME_PATTERN = 4'b0011,
    parameter int         SETTLE_CYCLES = 16,
    parameter int         CHECK_CYCLES  = 64,
    parameter int         MIN_WINDOW    = 4,
    parameter int         MAX_SLIPS     = 4,
    parameter int         ERR_LIMIT     = 8,
    parameter bit         AUTO_REALIGN  = 1'b1
) (
    input  logic       DCO_2D,
    input  logic       rst_n_in,
    input  logic       start,
    input  logic       idelay_rdy,
    input  logic [3:0] FR_out,
    output logic [4:0] delay_val,
    output logic       bitslip,
    output logic       busy,
    output logic       aligned,
    output logic       fail,
    output logic [4:0] window_start,
    output logic [5:0] window_len
);

    localparam int SET_W  = $clog2(SETTLE_CYCLES + 1);
    localparam int CHK_W  = $clog2(CHECK_CYCLES + 1);
    localparam int SLIP_W = $clog2(MAX_SLIPS + 1);
    localparam int ERR_W  = $clog2(ERR_LIMIT + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_WAIT_RDY, S_SETTLE, S_CHECK, S_NEXT_TAP,
        S_CENTER, S_SLIP_CHECK, S_LOCKED, S_FAIL
    } state_t;

    state_t            state_q, state_d;
    state_t            ret_q, ret_d;
    logic              rdy_meta_q, rdy_s_q;
    logic [4:0]        delay_q, delay_d;
    logic [SET_W-1:0]  settle_cnt_q, settle_cnt_d;
    logic [CHK_W-1:0]  check_cnt_q, check_cnt_d;
    logic [SLIP_W-1:0] slip_cnt_q, slip_cnt_d;
    logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;
    logic [3:0]        cap_q, cap_d;
    logic [4:0]        run_start_q, run_start_d;
    logic [5:0]        run_len_q, run_len_d;
    logic [4:0]        best_start_q, best_start_d;
    logic [5:0]        best_len_q, best_len_d;
    logic [4:0]        win_start_q, win_start_d;
    logic [5:0]        win_len_q, win_len_d;

    logic [7:0] pat2;
    logic [3:0] rot_match;
    logic [5:0] win_len_m1;
    logic       word_ok;
    logic       tap_done;
    logic       tap_good;

    // A tap can only be good if its word is some rotation of the frame pattern.
    assign pat2 = {FRAME_PATTERN, FRAME_PATTERN};
    for (genvar gi = 0; gi < 4; gi++) begin : g_rot
        assign rot_match[gi] = (FR_out == pat2[gi +: 4]);
    end

    assign win_len_m1 = win_len_q - 6'd1;

    assign delay_val    = delay_q;
    assign window_start = win_start_q;
    assign window_len   = win_len_q;
    assign busy    = (state_q == S_WAIT_RDY) || (state_q == S_SETTLE) || (state_q == S_CHECK) ||
                     (state_q == S_NEXT_TAP) || (state_q == S_CENTER) || (state_q == S_SLIP_CHECK);
    assign aligned = (state_q == S_LOCKED);
    assign fail    = (state_q == S_FAIL);

    always_ff @(posedge DCO_2D or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q      <= S_IDLE;
            ret_q        <= S_IDLE;
            rdy_meta_q   <= 1'b0;
            rdy_s_q      <= 1'b0;
            delay_q      <= '0;
            settle_cnt_q <= '0;
            check_cnt_q  <= '0;
            slip_cnt_q   <= '0;
            err_cnt_q    <= '0;
            cap_q        <= '0;
            run_start_q  <= '0;
            run_len_q    <= '0;
            best_start_q <= '0;
            best_len_q   <= '0;
            win_start_q  <= '0;
            win_len_q    <= '0;
        end else begin
            state_q      <= state_d;
            ret_q        <= ret_d;
            rdy_meta_q   <= idelay_rdy;
            rdy_s_q      <= rdy_meta_q;
            delay_q      <= delay_d;
            settle_cnt_q <= settle_cnt_d;
            check_cnt_q  <= check_cnt_d;
            slip_cnt_q   <= slip_cnt_d;
            err_cnt_q    <= err_cnt_d;
            cap_q        <= cap_d;
            run_start_q  <= run_start_d;
            run_len_q    <= run_len_d;
            best_start_q <= best_start_d;
            best_len_q   <= best_len_d;
            win_start_q  <= win_start_d;
            win_len_q    <= win_len_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        ret_d        = ret_q;
        delay_d      = delay_q;
        settle_cnt_d = '0;
        check_cnt_d  = '0;
        slip_cnt_d   = slip_cnt_q;
        err_cnt_d    = '0;
        cap_d        = cap_q;
        run_start_d  = run_start_q;
        run_len_d    = run_len_q;
        best_start_d = best_start_q;
        best_len_d   = best_len_q;
        win_start_d  = win_start_q;
        win_len_d    = win_len_q;
        bitslip      = 1'b0;
        word_ok      = 1'b0;
        tap_done     = 1'b0;
        tap_good     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_WAIT_RDY;
            end
            S_WAIT_RDY: begin
                if (rdy_s_q) begin
                    state_d = S_SETTLE;
                    ret_d   = S_CHECK;
                end
            end
            S_SETTLE: begin
                if (settle_cnt_q == SET_W'(SETTLE_CYCLES - 1)) state_d = ret_q;
                else settle_cnt_d = settle_cnt_q + SET_W'(1);
            end
            S_CHECK: begin
                word_ok = (check_cnt_q == '0) ? (|rot_match) : (FR_out == cap_q);
                if (check_cnt_q == '0) cap_d = FR_out;
                if (!word_ok) begin
                    tap_done = 1'b1;
                end else if (check_cnt_q == CHK_W'(CHECK_CYCLES - 1)) begin
                    tap_done = 1'b1;
                    tap_good = 1'b1;
                end else begin
                    check_cnt_d = check_cnt_q + CHK_W'(1);
                end
                if (tap_done) begin
                    state_d = S_NEXT_TAP;
                    if (tap_good) begin
                        if (run_len_q == '0) run_start_d = delay_q;
                        run_len_d = run_len_q + 6'd1;
                    end else begin
                        // Strictly longer only, so ties keep the lowest-start window.
                        if (run_len_q > best_len_q) begin
                            best_start_d = run_start_q;
                            best_len_d   = run_len_q;
                        end
                        run_len_d = '0;
                    end
                end
            end
            S_NEXT_TAP: begin
                if (delay_q != 5'd31) begin
                    delay_d = delay_q + 5'd1;
                    state_d = S_SETTLE;
                    ret_d   = S_CHECK;
                end else begin
                    if (run_len_q > best_len_q) begin
                        win_start_d = run_start_q;
                        win_len_d   = run_len_q;
                    end else begin
                        win_start_d = best_start_q;
                        win_len_d   = best_len_q;
                    end
                    state_d = S_CENTER;
                end
            end
            S_CENTER: begin
                if (win_len_q < 6'(MIN_WINDOW)) begin
                    state_d = S_FAIL;
                end else begin
                    delay_d    = win_start_q + win_len_m1[5:1];
                    slip_cnt_d = '0;
                    state_d    = S_SETTLE;
                    ret_d      = S_SLIP_CHECK;
                end
            end
            S_SLIP_CHECK: begin
                if (FR_out == FRAME_PATTERN) begin
                    state_d = S_LOCKED;
                end else if (slip_cnt_q == SLIP_W'(MAX_SLIPS)) begin
                    state_d = S_FAIL;
                end else begin
                    bitslip    = 1'b1;
                    slip_cnt_d = slip_cnt_q + SLIP_W'(1);
                    state_d    = S_SETTLE;
                    ret_d      = S_SLIP_CHECK;
                end
            end
            S_LOCKED: begin
                if (start) begin
                    state_d = S_WAIT_RDY;
                end else if (FR_out != FRAME_PATTERN) begin
                    if (err_cnt_q == ERR_W'(ERR_LIMIT - 1)) state_d = AUTO_REALIGN ? S_WAIT_RDY : S_FAIL;
                    else err_cnt_d = err_cnt_q + ERR_W'(1);
                end
            end
            S_FAIL: begin
                if (start) state_d = S_WAIT_RDY;
            end
            default: state_d = S_IDLE;
        endcase

        // Losing IDELAYCTRL ready mid-training invalidates every tap measured so far.
        if (busy && (state_q != S_WAIT_RDY) && !rdy_s_q) begin
            state_d = S_WAIT_RDY;
            bitslip = 1'b0;
        end

        if (state_d == S_WAIT_RDY) begin
            delay_d      = '0;
            slip_cnt_d   = '0;
            err_cnt_d    = '0;
            cap_d        = '0;
            run_start_d  = '0;
            run_len_d    = '0;
            best_start_d = '0;
            best_len_d   = '0;
            win_start_d  = '0;
            win_len_d    = '0;
        end
    end

endmodule

// File: tb/tb_ltc2195_frame_aligner.sv
// Directed bench for ltc2195_frame_aligner: a tap-dependent FR_out model drives
// windows, bitslip phase and corruption; results are checked against hand values.
`timescale 1ns/1ps
module tb_ltc2195_frame_aligner;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       idelay_rdy = 1'b1;
    logic [3:0] fr = 4'b0000;
    logic [4:0] delay_val;
    logic       bitslip;
    logic       busy;
    logic       aligned;
    logic       fail;
    logic [4:0] window_start;
    logic [5:0] window_len;

    logic [7:0]  pat2 = 8'b0011_0011;
    logic [31:0] good_mask = 32'h0;
    int          r0 = 0;
    int          rr;
    bit          stuck = 1'b0;
    int          pcyc = 0;
    int          force_lo = 0;
    int          force_hi = 0;
    int          cyc = 0;
    int          slips_total = 0;
    int          slip_base = 0;
    int          last_slip = -1;
    int          min_gap = 1000000;
    int          n_checks = 0;
    int          n_errors = 0;

    ltc2195_frame_aligner dut (
        .DCO_2D      (clk),
        .rst_n_in    (rst_n),
        .start       (start),
        .idelay_rdy  (idelay_rdy),
        .FR_out      (fr),
        .delay_val   (delay_val),
        .bitslip     (bitslip),
        .busy        (busy),
        .aligned     (aligned),
        .fail        (fail),
        .window_start(window_start),
        .window_len  (window_len)
    );

    always #5 clk = ~clk;

    // Frame-lane model: stable rotated pattern on good taps, noise elsewhere.
    always @(posedge clk) begin
        pcyc++;
        #1;
        if (pcyc > force_lo && pcyc <= force_hi) begin
            fr = 4'b0101;
        end else if (stuck && window_len != 6'd0) begin
            fr = 4'b0000;
        end else if (good_mask[delay_val]) begin
            rr = (r0 - (slips_total - slip_base)) & 3;
            fr = pat2[rr +: 4];
        end else begin
            fr = 4'($urandom);
        end
    end

    always @(negedge clk) begin
        cyc++;
        if (bitslip) begin
            slips_total++;
            if (last_slip >= 0 && (cyc - last_slip) < min_gap) min_gap = cyc - last_slip;
            last_slip = cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_start(input logic [31:0] mask, input int phase, input bit stk);
        @(negedge clk);
        good_mask = mask;
        r0        = phase;
        stuck     = stk;
        slip_base = slips_total;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (busy && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done"}, 32'(n < 20000), 32'd1);
        $display("train %s: ws=%0d wl=%0d delay=%0d slips=%0d aligned=%0d fail=%0d",
                 tag, window_start, window_len, delay_val, slips_total - slip_base, aligned, fail);
    endtask

    task automatic wait_delay(input string tag, input logic [4:0] v);
        int n;
        n = 0;
        while (delay_val != v && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_reach"}, 32'(n < 20000), 32'd1);
    endtask

    task automatic corrupt(input int n);
        @(negedge clk);
        force_lo = pcyc;
        force_hi = pcyc + n;
        repeat (12) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset_outs", 32'({delay_val, bitslip, busy, aligned, fail, window_start, window_len}), 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);

        // Good taps 8..19, two slips needed.
        do_start(32'h000F_FF00, 2, 1'b0);
        check("t1_busy", 32'(busy), 32'd1);
        wait_done("t1");
        check("t1_ws", 32'(window_start), 32'd8);
        check("t1_wl", 32'(window_len), 32'd12);
        check("t1_delay", 32'(delay_val), 32'd13);
        check("t1_slips", 32'(slips_total - slip_base), 32'd2);
        check("t1_aligned", 32'(aligned), 32'd1);
        check("t1_fail", 32'(fail), 32'd0);

        // Equal-length windows 2..6 and 20..24: lowest start wins.
        do_start(32'h01F0_007C, 0, 1'b0);
        wait_done("t2a");
        check("t2a_ws", 32'(window_start), 32'd2);
        check("t2a_wl", 32'(window_len), 32'd5);
        check("t2a_delay", 32'(delay_val), 32'd4);
        check("t2a_slips", 32'(slips_total - slip_base), 32'd0);
        check("t2a_aligned", 32'(aligned), 32'd1);

        // 2..6 and 20..27: the longer one wins.
        do_start(32'h0FF0_007C, 0, 1'b0);
        wait_done("t2b");
        check("t2b_ws", 32'(window_start), 32'd20);
        check("t2b_wl", 32'(window_len), 32'd8);
        check("t2b_delay", 32'(delay_val), 32'd23);

        // Window of 3 taps is too narrow.
        do_start(32'h0000_1C00, 0, 1'b0);
        wait_done("t3");
        check("t3_fail", 32'(fail), 32'd1);
        check("t3_aligned", 32'(aligned), 32'd0);
        check("t3_slips", 32'(slips_total - slip_base), 32'd0);
        check("t3_ws", 32'(window_start), 32'd10);
        check("t3_wl", 32'(window_len), 32'd3);
        do_start(32'h000F_FF00, 3, 1'b0);
        check("t3r_fail_clr", 32'(fail), 32'd0);
        check("t3r_busy", 32'(busy), 32'd1);
        wait_done("t3r");
        check("t3r_aligned", 32'(aligned), 32'd1);
        check("t3r_delay", 32'(delay_val), 32'd13);
        check("t3r_slips", 32'(slips_total - slip_base), 32'd3);

        // Frame word stuck at zero after centring: four slips then give up.
        do_start(32'h000F_FF00, 0, 1'b1);
        wait_done("t4");
        check("t4_slips", 32'(slips_total - slip_base), 32'd4);
        check("t4_fail", 32'(fail), 32'd1);
        check("t4_aligned", 32'(aligned), 32'd0);
        check("t4_slip_gap", 32'(min_gap >= 17), 32'd1);

        // Loss-of-lock threshold.
        do_start(32'h000F_FF00, 1, 1'b0);
        wait_done("t5");
        check("t5_aligned", 32'(aligned), 32'd1);
        corrupt(7);
        check("t5_err7_aligned", 32'(aligned), 32'd1);
        check("t5_err7_busy", 32'(busy), 32'd0);
        corrupt(8);
        check("t5_err8_aligned", 32'(aligned), 32'd0);
        check("t5_err8_busy", 32'(busy), 32'd1);
        check("t5_err8_delay", 32'(delay_val), 32'd0);
        wait_done("t5r");
        check("t5r_aligned", 32'(aligned), 32'd1);

        // IDELAYCTRL ready drops mid-sweep.
        do_start(32'h000F_FF00, 0, 1'b0);
        wait_delay("t6", 5'd15);
        idelay_rdy = 1'b0;
        repeat (5) @(negedge clk);
        check("t6_busy", 32'(busy), 32'd1);
        check("t6_delay0", 32'(delay_val), 32'd0);
        repeat (20) @(negedge clk);
        check("t6_hold_delay", 32'(delay_val), 32'd0);
        check("t6_hold_wl", 32'(window_len), 32'd0);
        idelay_rdy = 1'b1;
        wait_done("t6");
        check("t6_aligned", 32'(aligned), 32'd1);
        check("t6_delay", 32'(delay_val), 32'd13);

        // Asynchronous reset in the middle of a settle interval.
        do_start(32'h000F_FF00, 0, 1'b0);
        wait_delay("t7", 5'd3);
        repeat (2) @(negedge clk);
        check("t7_busy_before", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t7_async_outs", 32'({delay_val, bitslip, busy, aligned, fail, window_start, window_len}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("t7_idle", 32'({busy, aligned, fail}), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
